piso_shift_controller: RTL and testbench
========================================

// Module: piso_shift_controller
// PURPOSE
//   Sequencer for the 4-bit adder -> PISO serialiser path. On a start request it
//   waits for the adder result to settle, pulses latch_c to load the PISO, then
//   issues shift_c once per accepted serial bit, MSB first, under ready/valid
//   backpressure from the serial consumer. It reports busy/done to the issuing
//   control logic and sits beside the PISO, driving its latch_c/shift_c pins.
// PARAMETERS
//   WIDTH      4  PISO width; number of serial bits per frame (>=2)
//   ADDER_LAT  1  cycles waited after start before latching (0 = latch next cycle)
// PORTS
//   clk         in   1         single clock, all state on posedge
//   rst_n       in   1         asynchronous, active-low reset
//   start       in   1         request a frame; sampled only in IDLE
//   abort       in   1         cancel the current frame, any state
//   ser_ready   in   1         consumer accepts the current serial bit this cycle
//   latch_c     out  1         to PISO: load the adder result on this edge
//   shift_c     out  1         to PISO: shift left one bit on this edge
//   ser_valid   out  1         PISO output c holds a valid bit this cycle
//   ser_last    out  1         current bit is bit index WIDTH-1 (LSB)
//   bit_idx     out  clog2(W)  index of the bit currently on c (0 = MSB)
//   busy        out  1         high in every state except IDLE
//   done        out  1         one-cycle pulse: frame fully consumed
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, counters=0; all outputs 0 while in reset
//   and on the first cycle after release. PISO contents are not reset here;
//   consumers must qualify c with ser_valid.
//   States: IDLE -> SETTLE -> LATCH -> STREAM -> DONE -> IDLE.
//   - IDLE: start=1 -> SETTLE (ADDER_LAT>0) or LATCH (ADDER_LAT=0). busy=0.
//   - SETTLE: wait counter runs ADDER_LAT cycles, then LATCH.
//   - LATCH: latch_c=1 for exactly one cycle; bit_idx cleared; next STREAM.
//   - STREAM: ser_valid=1; bit_idx = bits already shifted out.
//       ser_ready=1 & bit_idx<WIDTH-1: shift_c=1 in the same cycle, bit_idx+1.
//       ser_ready=1 & bit_idx==WIDTH-1: shift_c=0, go to DONE.
//       ser_ready=0: hold; shift_c=0, bit_idx unchanged (bit stays on c).
//   - DONE: done=1 for one cycle, busy=1; next IDLE. start here is ignored.
//   Decode: latch_c, ser_valid, ser_last, busy, done are Moore, decoded from
//   registered state. shift_c = STREAM & ser_ready & ~ser_last, which is
//   combinational on ser_ready. ser_last = STREAM & bit_idx==WIDTH-1.
//   latch_c and shift_c are never high together.
//   Latency: with ADDER_LAT=L, the first ser_valid comes L+2 cycles after the
//   start edge. A full frame with ser_ready tied high takes L+WIDTH+3 cycles to
//   return to IDLE (L+2 to first ser_valid, WIDTH STREAM cycles, 1 DONE cycle).
//   abort=1: next edge -> IDLE from any state, no done pulse, no latch/shift in
//   the abort cycle. abort has priority over start and ser_ready.
//   start held high: one frame per IDLE visit, back-to-back frames with one
//   IDLE cycle between them. Counters never wrap: bit_idx saturates at WIDTH-1.
// STRUCTURE
//   Shared package/header: state encoding localparams (S_IDLE, S_SETTLE,
//   S_LATCH, S_STREAM, S_DONE, 3-bit) and a CLOG2 helper macro/function.
//   Single module, no sub-modules needed: state reg, settle counter, bit counter.
//   The PISO itself is instantiated by the parent, not inside this block.
// TESTING  (WIDTH=4, ADDER_LAT=1, PISO + adder in bench, adder out=4'b1011)
//   T1 start pulse, ser_ready=1 -> latch_c at cycle 2; c=1,0,1,1 with ser_valid
//     on cycles 3-6; shift_c on cycles 3-5; ser_last on cycle 6; done on cycle 7.
//   T2 ser_ready low for 3 cycles at bit_idx=1 -> c holds 0, no shift_c, bit_idx=1
//     steady; resumes with 1,1; done 3 cycles later than in T1.
//   T3 abort at bit_idx=2 -> IDLE next cycle; busy=0, no done; new start gives a
//     full 4-bit frame again from bit_idx 0.
//   T4 rst_n low mid-STREAM -> all outputs 0 immediately (async); IDLE on release.
//   T5 start held high for 20 cycles -> frames separated by exactly one IDLE
//     cycle; start pulses during busy/DONE do not create extra frames.
//   T6 ADDER_LAT=0 build -> latch_c the cycle after start; first ser_valid at +2.

Source files
------------

// File: rtl/piso_shift_controller_pkg.sv
// Shared definitions for the adder -> PISO serialiser sequencer: FSM state
// encoding and a constant-evaluable ceil(log2) helper for port/counter widths.
package piso_shift_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_LATCH  = 3'd2,
        S_STREAM = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Smallest n with 2**n >= value; used at elaboration time only.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/piso_shift_controller_if.sv
// Control/serial handshake bundle between the issuing logic, the sequencer
// and the serial consumer. The master side drives requests and ser_ready;
// the slave side is the sequencer itself.
interface piso_shift_controller_if
    import piso_shift_controller_pkg::*;
#(
    parameter int WIDTH = 4
);
    localparam int BIT_W = clog2(WIDTH);

    logic             start;
    logic             abort;
    logic             ser_ready;
    logic             latch_c;
    logic             shift_c;
    logic             ser_valid;
    logic             ser_last;
    logic [BIT_W-1:0] bit_idx;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, ser_ready,
        input  latch_c, shift_c, ser_valid, ser_last, bit_idx, busy, done
    );

    modport slave (
        input  start, abort, ser_ready,
        output latch_c, shift_c, ser_valid, ser_last, bit_idx, busy, done
    );

endinterface

// File: rtl/piso_shift_controller.sv
// Sequencer for the adder -> PISO path: waits ADDER_LAT cycles for the sum to
// settle, pulses latch_c to load the PISO, then issues shift_c once per
// accepted serial bit (MSB first) under ser_ready backpressure.
module piso_shift_controller
    import piso_shift_controller_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int ADDER_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    piso_shift_controller_if.slave bus
);

    localparam int                BIT_W     = clog2(WIDTH);
    localparam int                WAIT_W    = (ADDER_LAT > 1) ? clog2(ADDER_LAT) : 1;
    localparam logic [BIT_W-1:0]  LAST_IDX  = BIT_W'(WIDTH - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((ADDER_LAT > 0) ? ADDER_LAT - 1 : 0);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic [BIT_W-1:0]  r_bit_idx;
    logic [BIT_W-1:0]  w_bit_idx_nxt;

    logic r_latch;
    logic r_valid;
    logic r_last;
    logic r_busy;
    logic r_done;

    // Next-state, settle-counter and bit-counter logic; abort wins over everything.
    always_comb begin
        // NOTE: every target gets a default first, so no path can infer a latch.
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait;
        w_bit_idx_nxt = r_bit_idx;
        if (bus.abort) begin
            w_state_nxt   = S_IDLE;
            w_wait_nxt    = '0;
            w_bit_idx_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        w_wait_nxt  = '0;
                        w_state_nxt = (ADDER_LAT == 0) ? S_LATCH : S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_wait == WAIT_LAST) begin
                        w_wait_nxt  = '0;
                        w_state_nxt = S_LATCH;
                    end else begin
                        w_wait_nxt = r_wait + 1'b1;
                    end
                end
                S_LATCH: begin
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = S_STREAM;
                end
                S_STREAM: begin
                    if (bus.ser_ready) begin
                        if (r_bit_idx == LAST_IDX) begin
                            // Frame consumed; index returns to 0 outside STREAM.
                            w_bit_idx_nxt = '0;
                            w_state_nxt   = S_DONE;
                        end else begin
                            w_bit_idx_nxt = r_bit_idx + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt   = S_IDLE;
                    w_wait_nxt    = '0;
                    w_bit_idx_nxt = '0;
                end
            endcase
        end
    end

    // State, counters and Moore outputs, registered together from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_wait    <= '0;
            r_bit_idx <= '0;
            r_latch   <= 1'b0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            // NOTE: non-blocking, so every register here samples pre-edge values.
            r_state   <= w_state_nxt;
            r_wait    <= w_wait_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_latch   <= (w_state_nxt == S_LATCH);
            r_valid   <= (w_state_nxt == S_STREAM);
            r_last    <= (w_state_nxt == S_STREAM) && (w_bit_idx_nxt == LAST_IDX);
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= (w_state_nxt == S_DONE);
        end
    end

    // PISO strobes are suppressed in an abort cycle; shift_c follows ser_ready
    // combinationally and never fires on the last bit, so it never meets latch_c.
    assign bus.latch_c   = r_latch & ~bus.abort;
    assign bus.shift_c   = r_valid & bus.ser_ready & ~r_last & ~bus.abort;
    assign bus.ser_valid = r_valid;
    assign bus.ser_last  = r_last;
    assign bus.bit_idx   = r_bit_idx;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_piso_shift_controller.sv
// Bench for piso_shift_controller: two instances (ADDER_LAT=1 and ADDER_LAT=0)
// share stimulus, each feeds its own 4-bit PISO loaded from a bench adder
// value. A frame-level model (cycles since start, bits accepted) predicts
// every output each cycle; directed scenarios pin the model with literals.
module tb_piso_shift_controller;
    import piso_shift_controller_pkg::*;

    localparam int W = 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       ready;
    logic [3:0] adder_out;

    int n_checks = 0;
    int n_errors = 0;

    // Index i of each array below is also that instance's ADDER_LAT.
    piso_shift_controller_if #(.WIDTH(W)) if0 ();
    piso_shift_controller_if #(.WIDTH(W)) if1 ();

    piso_shift_controller #(.WIDTH(W), .ADDER_LAT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    piso_shift_controller #(.WIDTH(W), .ADDER_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    assign if0.start     = start;
    assign if0.abort     = abort;
    assign if0.ser_ready = ready;
    assign if1.start     = start;
    assign if1.abort     = abort;
    assign if1.ser_ready = ready;

    typedef struct packed {
        logic       latch_c;
        logic       shift_c;
        logic       ser_valid;
        logic       ser_last;
        logic       busy;
        logic       done;
        logic [1:0] bit_idx;
    } obs_t;

    obs_t       obs  [2];
    logic [3:0] piso [2];

    assign obs[0] = {if0.latch_c, if0.shift_c, if0.ser_valid, if0.ser_last, if0.busy, if0.done, if0.bit_idx};
    assign obs[1] = {if1.latch_c, if1.shift_c, if1.ser_valid, if1.ser_last, if1.busy, if1.done, if1.bit_idx};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side PISO per instance: load on latch_c, shift left on shift_c.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (obs[i].latch_c) piso[i] <= adder_out;
            else if (obs[i].shift_c) piso[i] <= {piso[i][2:0], 1'b0};
        end
    end

    // Frame-level model: age = cycles since the start edge, acc = bits accepted.
    bit         m_active [2];
    bit         m_done   [2];
    int         m_age    [2];
    int         m_acc    [2];
    logic [3:0] m_data   [2];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_active[i] <= 1'b0;
                m_done[i]   <= 1'b0;
                m_age[i]    <= 0;
                m_acc[i]    <= 0;
            end else if (abort) begin
                m_active[i] <= 1'b0;
                m_done[i]   <= 1'b0;
            end else if (m_done[i]) begin
                m_done[i] <= 1'b0;
            end else if (m_active[i]) begin
                if (m_age[i] == i + 1) m_data[i] <= adder_out;
                if (m_age[i] >= i + 2 && ready) begin
                    if (m_acc[i] == W - 1) begin
                        m_active[i] <= 1'b0;
                        m_done[i]   <= 1'b1;
                    end else begin
                        m_acc[i] <= m_acc[i] + 1;
                    end
                end
                m_age[i] <= m_age[i] + 1;
            end else if (start) begin
                m_active[i] <= 1'b1;
                m_age[i]    <= 1;
                m_acc[i]    <= 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin : cmp
        bit valid_e;
        bit last_e;
        for (int i = 0; i < 2; i++) begin
            valid_e = m_active[i] && (m_age[i] >= i + 2);
            last_e  = valid_e && (m_acc[i] == W - 1);
            check($sformatf("L%0d latch_c", i), 32'(obs[i].latch_c),
                  32'(m_active[i] && m_age[i] == i + 1 && !abort));
            check($sformatf("L%0d ser_valid", i), 32'(obs[i].ser_valid), 32'(valid_e));
            check($sformatf("L%0d ser_last", i), 32'(obs[i].ser_last), 32'(last_e));
            check($sformatf("L%0d shift_c", i), 32'(obs[i].shift_c),
                  32'(valid_e && ready && !last_e && !abort));
            check($sformatf("L%0d busy", i), 32'(obs[i].busy), 32'(m_active[i] || m_done[i]));
            check($sformatf("L%0d done", i), 32'(obs[i].done), 32'(m_done[i]));
            if (valid_e) begin
                check($sformatf("L%0d bit_idx", i), 32'(obs[i].bit_idx), 32'(m_acc[i]));
                check($sformatf("L%0d c", i), 32'(piso[i][3]), 32'(m_data[i][W - 1 - m_acc[i]]));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            next_cycle();
            start = 1'b0;
            abort = 1'b0;
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        logic [3:0] pat;
        int         latch_cnt;
        int         done_cnt;
        int         idle_cnt;
        pat       = 4'b1011;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        ready     = 1'b0;
        adder_out = 4'b1011;

        // Reset state
        @(negedge clk);
        check("reset busy", 32'(if1.busy), 32'd0);
        check("reset ser_valid", 32'(if1.ser_valid), 32'd0);
        check("reset bit_idx", 32'(if1.bit_idx), 32'd0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("post-release busy", 32'(if1.busy), 32'd0);
        idle_cycles(2);

        // T1 + T6: single start pulse, ready tied high
        start = 1'b1;
        ready = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            next_cycle();
            start = 1'b0;
            @(negedge clk);
            check($sformatf("T1 latch_c c%0d", cyc), 32'(if1.latch_c), 32'(cyc == 2));
            check($sformatf("T1 ser_valid c%0d", cyc), 32'(if1.ser_valid), 32'(cyc >= 3 && cyc <= 6));
            check($sformatf("T1 shift_c c%0d", cyc), 32'(if1.shift_c), 32'(cyc >= 3 && cyc <= 5));
            check($sformatf("T1 ser_last c%0d", cyc), 32'(if1.ser_last), 32'(cyc == 6));
            check($sformatf("T1 done c%0d", cyc), 32'(if1.done), 32'(cyc == 7));
            check($sformatf("T1 busy c%0d", cyc), 32'(if1.busy), 32'(cyc <= 7));
            if (cyc >= 3 && cyc <= 6)
                check($sformatf("T1 c c%0d", cyc), 32'(piso[1][3]), 32'(pat[6 - cyc]));
            check($sformatf("T6 latch_c c%0d", cyc), 32'(if0.latch_c), 32'(cyc == 1));
            check($sformatf("T6 ser_valid c%0d", cyc), 32'(if0.ser_valid), 32'(cyc >= 2 && cyc <= 5));
        end
        idle_cycles(2);

        // T2: ser_ready low for 3 cycles while bit_idx=1
        start = 1'b1;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            next_cycle();
            start = 1'b0;
            ready = !(cyc >= 4 && cyc <= 6);
            @(negedge clk);
            if (cyc >= 4 && cyc <= 6) begin
                check($sformatf("T2 bit_idx c%0d", cyc), 32'(if1.bit_idx), 32'd1);
                check($sformatf("T2 shift_c c%0d", cyc), 32'(if1.shift_c), 32'd0);
                check($sformatf("T2 c c%0d", cyc), 32'(piso[1][3]), 32'd0);
            end
            check($sformatf("T2 done c%0d", cyc), 32'(if1.done), 32'(cyc == 10));
        end
        ready = 1'b1;
        idle_cycles(2);

        // T3: abort at bit_idx=2, then a fresh frame
        start = 1'b1;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            next_cycle();
            start = 1'b0;
            abort = (cyc == 5);
            @(negedge clk);
            if (cyc == 5) begin
                check("T3 bit_idx at abort", 32'(if1.bit_idx), 32'd2);
                check("T3 shift_c at abort", 32'(if1.shift_c), 32'd0);
            end
            if (cyc == 6) check("T3 busy after abort", 32'(if1.busy), 32'd0);
            if (cyc >= 6) check($sformatf("T3 no done c%0d", cyc), 32'(if1.done), 32'd0);
        end
        abort = 1'b0;
        start = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            next_cycle();
            start = 1'b0;
            @(negedge clk);
            if (cyc == 3) check("T3 restart bit_idx", 32'(if1.bit_idx), 32'd0);
            check($sformatf("T3 restart done c%0d", cyc), 32'(if1.done), 32'(cyc == 7));
        end
        idle_cycles(2);

        // T4: asynchronous reset mid-STREAM
        start = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            next_cycle();
            start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("T4 async busy", 32'(if1.busy), 32'd0);
        check("T4 async ser_valid", 32'(if1.ser_valid), 32'd0);
        check("T4 async shift_c", 32'(if1.shift_c), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("T4 idle after release", 32'(if1.busy), 32'd0);
        idle_cycles(2);

        // T5: start held high for 20 cycles
        latch_cnt = 0;
        done_cnt  = 0;
        idle_cnt  = 0;
        start     = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            next_cycle();
            if (cyc == 20) start = 1'b0;
            @(negedge clk);
            if (if1.latch_c) latch_cnt++;
            if (if1.done) done_cnt++;
            if (cyc <= 23 && !if1.busy) idle_cnt++;
        end
        check("T5 frames latched", 32'(latch_cnt), 32'd3);
        check("T5 done pulses", 32'(done_cnt), 32'd3);
        check("T5 idle cycles between", 32'(idle_cnt), 32'd2);

        // Randomised traffic against the model
        for (int k = 0; k < 800; k++) begin
            next_cycle();
            start     = ($urandom_range(0, 3) == 0);
            abort     = ($urandom_range(0, 31) == 0);
            ready     = ($urandom_range(0, 3) != 0);
            adder_out = 4'($urandom);
        end
        idle_cycles(12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
